elevator_ctrl: RTL and testbench

//  3-floor elevator controller FSM: latches hall/car calls, schedules travel (SCAN), times doors.

---
 rtl/elevator_pkg.sv | 38 +++
 rtl/elev_timer.sv | 36 +++
 rtl/elevator_ctrl.sv | 139 +++++++++++++
 tb/tb_elevator_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared state encodings, display codes and floor helpers for elevator_ctrl
package elevator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DOOR  = 3'd1,
    ST_MOVE  = 3'd2,
    ST_HALT  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  localparam logic [2:0] CODE_FAULT     = 3'b000;
  localparam logic [2:0] CODE_HALT      = 3'b111;
  localparam logic [2:0] CODE_STOP_BASE = 3'b000;
  localparam logic [2:0] CODE_MOVE_BASE = 3'b100;

  localparam logic [1:0] FLOOR_BOTTOM = 2'd1;

  // Floors are numbered 1..3; bit (f-1) of a call vector belongs to floor f.
  function automatic logic [2:0] floor_bit(input logic [1:0] f);
    return 3'b001 << (f - FLOOR_BOTTOM);
  endfunction

  // Call bits strictly above (up=1) or strictly below (up=0) floor f.
  function automatic logic [2:0] beyond_mask(input logic [1:0] f, input logic up);
    return up ? (3'b111 << f) : (floor_bit(f) - 3'b001);
  endfunction

  function automatic logic [2:0] code_for(input state_t s, input logic [1:0] f);
    case (s)
      ST_IDLE, ST_DOOR: return CODE_STOP_BASE | {1'b0, f};
      ST_MOVE:          return CODE_MOVE_BASE | {1'b0, f - FLOOR_BOTTOM};
      ST_HALT:          return CODE_HALT;
      default:          return CODE_FAULT;
    endcase
  endfunction

endpackage

// File: rtl/elev_timer.sv
// rtl/elev_timer.sv - loadable saturating down-counter shared by door and travel timing
module elev_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         clr_i,
  input  logic [W-1:0] value_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/elevator_ctrl.sv
// rtl/elevator_ctrl.sv - 3-floor SCAN elevator controller: call latch, travel/door timing, display code
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] call_req,
  input  logic       estop,
  input  logic       fault,
  output logic [2:0] floor_code,
  output logic       door_open,
  output logic       moving,
  output logic       dir_up,
  output logic [2:0] pending
);

  localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES);
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);

  state_t        state_q, state_d;
  logic [1:0]    floor_q, floor_d, arr_floor;
  logic          dir_q, dir_d;
  logic [2:0]    pend_q, pend_d;
  logic [2:0]    code_q, code_d;
  logic [2:0]    cur_bit, arr_bit, req;
  logic          tmr_load, tmr_clr, tmr_zero;
  logic [TW-1:0] tmr_val;

  elev_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (tmr_load),
    .clr_i   (tmr_clr),
    .value_i (tmr_val),
    .zero_o  (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dir_d     = dir_q;
    tmr_load  = 1'b0;
    tmr_clr   = 1'b0;
    tmr_val   = DOOR_LOAD;
    cur_bit   = floor_bit(floor_q);
    arr_floor = dir_q ? floor_q + 2'd1 : floor_q - 2'd1;
    arr_bit   = floor_bit(arr_floor);
    // A current-floor call while the door is open only extends the door, it is never queued.
    req       = call_req & ((state_q == ST_DOOR) ? ~cur_bit : 3'b111);
    pend_d    = pend_q | req;

    if (fault || state_q == ST_FAULT) begin
      state_d = ST_FAULT;
      pend_d  = '0;
      tmr_clr = 1'b1;
    end else if (estop) begin
      state_d = ST_HALT;
      tmr_clr = 1'b1;
    end else begin
      case (state_q)
        // IDLE acts on already-latched calls only, giving a two-edge call-to-door latency.
        ST_IDLE: begin
          if ((pend_q & cur_bit) != '0) begin
            state_d  = ST_DOOR;
            pend_d   = pend_d & ~cur_bit;
            tmr_load = 1'b1;
          end else if ((pend_q & beyond_mask(floor_q, dir_q)) != '0) begin
            state_d  = ST_MOVE;
            tmr_load = 1'b1;
            tmr_val  = TRAVEL_LOAD;
          end else if ((pend_q & beyond_mask(floor_q, ~dir_q)) != '0) begin
            state_d  = ST_MOVE;
            dir_d    = ~dir_q;
            tmr_load = 1'b1;
            tmr_val  = TRAVEL_LOAD;
          end
        end
        ST_DOOR: begin
          if ((call_req & cur_bit) != '0) begin
            tmr_load = 1'b1;
          end else if (tmr_zero) begin
            state_d = ST_IDLE;
          end
        end
        ST_MOVE: begin
          if (tmr_zero) begin
            floor_d = arr_floor;
            if ((pend_d & arr_bit) != '0) begin
              state_d  = ST_DOOR;
              pend_d   = pend_d & ~arr_bit;
              tmr_load = 1'b1;
            end else if ((pend_d & beyond_mask(arr_floor, dir_q)) != '0) begin
              tmr_load = 1'b1;
              tmr_val  = TRAVEL_LOAD;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_HALT: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_FAULT;
        end
      endcase
    end

    code_d = code_for(state_d, floor_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      floor_q <= FLOOR_BOTTOM;
      dir_q   <= 1'b1;
      pend_q  <= '0;
      code_q  <= code_for(ST_IDLE, FLOOR_BOTTOM);
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      code_q  <= code_d;
    end
  end

  assign floor_code = code_q;
  assign door_open  = (state_q == ST_DOOR);
  assign moving     = (state_q == ST_MOVE);
  assign dir_up     = dir_q;
  assign pending    = pend_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// tb/tb_elevator_ctrl.sv - self-checking bench for elevator_ctrl with an in-bench behavioural model
module tb_elevator_ctrl;

  localparam int TRAVEL = 8;
  localparam int DOOR   = 4;
  localparam int M_IDLE = 0, M_DOOR = 1, M_MOVE = 2, M_HALT = 3, M_FAULT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] call_req = 3'b000;
  logic       estop = 1'b0;
  logic       fault = 1'b0;
  logic [2:0] floor_code;
  logic       door_open, moving, dir_up;
  logic [2:0] pending;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  int       m_mode, m_floor, m_left;
  bit       m_up;
  bit [2:0] m_pend;

  elevator_ctrl #(.TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR)) dut (
    .clk        (clk),
    .rst        (rst),
    .call_req   (call_req),
    .estop      (estop),
    .fault      (fault),
    .floor_code (floor_code),
    .door_open  (door_open),
    .moving     (moving),
    .dir_up     (dir_up),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic bit any_beyond(input bit [2:0] p, input int f, input bit up);
    for (int i = 1; i <= 3; i++) begin
      if (p[i-1] && (up ? (i > f) : (i < f))) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int exp_code();
    case (m_mode)
      M_IDLE, M_DOOR: return m_floor;
      M_MOVE:         return 4 + m_floor - 1;
      M_HALT:         return 7;
      default:        return 0;
    endcase
  endfunction

  // Reference model: advances on every rising edge from the same inputs as the DUT.
  always @(posedge clk) begin
    bit [2:0] req, old;
    if (rst) begin
      m_mode = M_IDLE; m_floor = 1; m_up = 1'b1; m_pend = 3'b000; m_left = 0;
    end else if (fault || m_mode == M_FAULT) begin
      m_mode = M_FAULT; m_pend = 3'b000;
    end else begin
      req = call_req;
      if (m_mode == M_DOOR) req[m_floor-1] = 1'b0;
      old = m_pend;
      m_pend = m_pend | req;
      if (estop) begin
        m_mode = M_HALT;
      end else begin
        case (m_mode)
          M_IDLE: begin
            if (old[m_floor-1]) begin
              m_pend[m_floor-1] = 1'b0; m_mode = M_DOOR; m_left = DOOR;
            end else if (any_beyond(old, m_floor, m_up)) begin
              m_mode = M_MOVE; m_left = TRAVEL;
            end else if (any_beyond(old, m_floor, !m_up)) begin
              m_up = !m_up; m_mode = M_MOVE; m_left = TRAVEL;
            end
          end
          M_DOOR: begin
            if (call_req[m_floor-1]) m_left = DOOR;
            else begin
              m_left--;
              if (m_left == 0) m_mode = M_IDLE;
            end
          end
          M_MOVE: begin
            m_left--;
            if (m_left == 0) begin
              m_floor = m_up ? m_floor + 1 : m_floor - 1;
              if (m_pend[m_floor-1]) begin
                m_pend[m_floor-1] = 1'b0; m_mode = M_DOOR; m_left = DOOR;
              end else if (any_beyond(m_pend, m_floor, m_up)) begin
                m_left = TRAVEL;
              end else begin
                m_mode = M_IDLE;
              end
            end
          end
          default: m_mode = M_IDLE;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_floor_code", floor_code, exp_code());
      check("model_door_open", door_open, m_mode == M_DOOR);
      check("model_moving", moving, m_mode == M_MOVE);
      check("model_dir_up", dir_up, m_up);
      check("model_pending", pending, m_pend);
    end
  end

  task automatic do_reset();
    rst = 1'b1; call_req = 3'b000; estop = 1'b0; fault = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_until_code(input logic [2:0] code, input int limit, input string name);
    int n = 0;
    while (floor_code !== code && n < limit) begin tick(); n++; end
    check(name, floor_code, code);
  endtask

  task automatic wait_door(input bit level, input int limit, input string name);
    int n = 0;
    while (door_open !== level && n < limit) begin tick(); n++; end
    check(name, door_open, level);
  endtask

  initial begin
    int cnt;
    int fault_age;
    int estop_hold;

    do_reset();
    chk_en = 1'b1;

    // Idle at floor 1 with no calls.
    for (int i = 0; i < 20; i++) tick();
    check("reset_code", floor_code, 3'b001);
    check("reset_door", door_open, 1'b0);
    check("reset_pending", pending, 3'b000);

    // Single pulse to floor 3: 8 cycles at 100, 8 at 101, door 4 at 011.
    call_req = 3'b100;
    tick();
    call_req = 3'b000;
    check("t2_latched", pending, 3'b100);
    for (int n = 2; n <= 22; n++) begin
      tick();
      if (n == 2)  check("t2_first_move", {moving, floor_code}, 4'b1100);
      if (n == 9)  check("t2_last_100", floor_code, 3'b100);
      if (n == 10) check("t2_first_101", floor_code, 3'b101);
      if (n == 17) check("t2_last_101", floor_code, 3'b101);
      if (n == 18) check("t2_door_open", {door_open, floor_code}, 4'b1011);
      if (n == 21) check("t2_door_last", door_open, 1'b1);
      if (n == 22) check("t2_idle_top", {door_open, floor_code, pending}, 7'b0011000);
    end

    // SCAN: call below arrives while passing floor 2 upward; floor 3 served first.
    do_reset();
    call_req = 3'b100;
    tick();
    call_req = 3'b000;
    wait_until_code(3'b101, 30, "t3_pass_floor2");
    call_req = 3'b001;
    tick();
    call_req = 3'b000;
    check("t3_both_pending", pending, 3'b101);
    wait_door(1'b1, 40, "t3_first_door");
    check("t3_first_stop", floor_code, 3'b011);
    check("t3_bit2_cleared", pending, 3'b001);
    wait_door(1'b0, 20, "t3_door_close");
    wait_door(1'b1, 60, "t3_second_door");
    check("t3_second_stop", {floor_code, pending}, 6'b001000);

    // Emergency halt mid-travel 1->2, then full travel restart.
    do_reset();
    call_req = 3'b010;
    tick();
    call_req = 3'b000;
    tick(); tick(); tick(); tick();
    estop = 1'b1;
    tick();
    check("t4_halt", {moving, floor_code}, 4'b0111);
    tick(); tick();
    estop = 1'b0;
    tick();
    check("t4_idle_after", floor_code, 3'b001);
    tick();
    check("t4_restart", {moving, floor_code}, 4'b1100);
    cnt = 1;
    for (int n = 0; n < 20 && floor_code == 3'b100; n++) begin
      tick();
      if (floor_code == 3'b100) cnt++;
    end
    check("t4_travel_cycles", cnt, TRAVEL);
    check("t4_arrive_door", {door_open, floor_code}, 4'b1010);

    // Repeated current-floor calls hold the door DOOR cycles past the last one.
    for (int k = 0; k < 6; k++) begin
      call_req = (k % 2 == 0) ? 3'b010 : 3'b000;
      tick();
      check("t6_pending_bit", pending[1], 1'b0);
    end
    call_req = 3'b000;
    cnt = 2;
    for (int n = 0; n < 10 && door_open; n++) begin
      tick();
      if (door_open) cnt++;
    end
    check("t6_door_hold", cnt, DOOR);

    // Fault during DOOR latches until reset; calls and estop ignored.
    call_req = 3'b010;
    tick();
    call_req = 3'b000;
    tick();
    check("t5_in_door", door_open, 1'b1);
    fault = 1'b1; call_req = 3'b101;
    tick();
    fault = 1'b0;
    check("t5_fault_code", {floor_code, pending}, 6'b000000);
    call_req = 3'b111; estop = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("t5_still_fault", {floor_code, pending, door_open, moving}, 8'b0);
    call_req = 3'b000; estop = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_reset_code", floor_code, 3'b001);

    // Randomized traffic with occasional estop, fault and reset.
    fault_age  = 0;
    estop_hold = 0;
    for (int c = 0; c < 4000; c++) begin
      call_req = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      if (estop_hold > 0) estop_hold--;
      else if ($urandom_range(0, 99) == 0) estop_hold = $urandom_range(1, 6);
      estop = (estop_hold > 0);
      fault = ($urandom_range(0, 799) == 0);
      rst   = ($urandom_range(0, 999) == 0) || (fault_age > 40);
      tick();
      fault_age = (m_mode == M_FAULT) ? fault_age + 1 : 0;
    end
    rst = 1'b0; call_req = 3'b000; estop = 1'b0; fault = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
